// File: rtl/data_mem_responder_pkg.sv
// Shared defines for the data-memory responder: word/address sizes, RV32I
// load/store funct3 encodings and the responder FSM state encoding.
package data_mem_responder_pkg;

    localparam int unsigned WORD_LEN   = 32;
    localparam int unsigned ADDR_SIZE  = 32;
    localparam int unsigned WAIT_CNT_W = 4;

    // RV32I funct3 for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational RV32I lane logic: extracts/extends load data from a stored
// word, merges store data into it, and flags illegal funct3 / misalignment.
// Ports:
//   write_i       1 = store, 0 = load
//   funct3_i      RV32I funct3
//   lane_i        addr[1:0]
//   word_i        current stored word
//   wdata_i       right-aligned store data
//   load_data_o   extended load result (0 on error)
//   store_word_o  word to write back (equals word_i on error)
//   err_o         illegal funct3 or misaligned access
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic                write_i,
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          lane_i,
    input  logic [WORD_LEN-1:0] word_i,
    input  logic [WORD_LEN-1:0] wdata_i,
    output logic [WORD_LEN-1:0] load_data_o,
    output logic [WORD_LEN-1:0] store_word_o,
    output logic                err_o
);

    logic [4:0]          byte_sh;
    logic [4:0]          half_sh;
    logic [WORD_LEN-1:0] shifted;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;

    assign byte_sh  = {lane_i, 3'b000};
    assign half_sh  = {lane_i[1], 4'b0000};
    assign shifted  = word_i >> byte_sh;
    assign byte_sel = shifted[7:0];
    assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    // Lane decode; any error forces a zero load and an unmodified word.
    always_comb begin
        load_data_o  = '0;
        store_word_o = word_i;
        err_o        = 1'b0;
        if (write_i) begin
            case (funct3_i)
                F3_B: store_word_o = (word_i & ~(32'h0000_00FF << byte_sh))
                                   | ({24'b0, wdata_i[7:0]} << byte_sh);
                F3_H: begin
                    if (lane_i[0]) err_o = 1'b1;
                    else store_word_o = (word_i & ~(32'h0000_FFFF << half_sh))
                                      | ({16'b0, wdata_i[15:0]} << half_sh);
                end
                F3_W: begin
                    if (lane_i != 2'b00) err_o = 1'b1;
                    else store_word_o = wdata_i;
                end
                default: err_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
                F3_BU: load_data_o = {24'b0, byte_sel};
                F3_H: begin
                    if (lane_i[0]) err_o = 1'b1;
                    else load_data_o = {{16{half_sel[15]}}, half_sel};
                end
                F3_HU: begin
                    if (lane_i[0]) err_o = 1'b1;
                    else load_data_o = {16'b0, half_sel};
                end
                F3_W: begin
                    if (lane_i != 2'b00) err_o = 1'b1;
                    else load_data_o = word_i;
                end
                default: err_o = 1'b1;
            endcase
        end
        if (err_o) begin
            load_data_o  = '0;
            store_word_o = word_i;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Stall-capable data-memory responder: one load/store at a time over a
// valid/ready request channel, result returned over a valid/ready response
// channel after WAIT_CYCLES+1 cycles.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_write                1 = store, 0 = load
//   req_addr                 byte address
//   req_funct3               RV32I funct3
//   req_wdata                right-aligned store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                load result (0 for stores and errors)
//   rsp_err                  request rejected, memory untouched
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [WORD_LEN-1:0]   req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_LEN-1:0]   rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [WORD_LEN-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [WORD_LEN-1:0]     wdata_q, wdata_d;

    logic [WORD_LEN-1:0]     mem [DEPTH_WORDS];

    logic [IDX_W-1:0]        idx_c;
    logic                    range_err_c;
    logic                    align_err_c;
    logic                    access_err_c;
    logic [WORD_LEN-1:0]     mem_rd_c;
    logic [WORD_LEN-1:0]     load_data_c;
    logic [WORD_LEN-1:0]     store_word_c;
    logic                    mem_we_c;

    assign idx_c        = addr_q[ADDR_WIDTH-1:2];
    assign range_err_c  = 32'(idx_c) >= 32'(DEPTH_WORDS);
    assign mem_rd_c     = mem[idx_c[MEM_AW-1:0]];
    assign access_err_c = range_err_c | align_err_c;

    mem_lane_align u_align (
        .write_i      (write_q),
        .funct3_i     (funct3_q),
        .lane_i       (addr_q[1:0]),
        .word_i       (mem_rd_c),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_c),
        .store_word_o (store_word_c),
        .err_o        (align_err_c)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[idx_c[MEM_AW-1:0]] <= store_word_c;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state logic. WAIT always holds the access cycle: wait_cnt counts the
    // extra cycles still to burn, and the access fires once it is zero, so a
    // request accepted at edge T responds after edge T+WAIT_CYCLES+1.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        write_d     = write_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        mem_we_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    funct3_d    = req_funct3;
                    wdata_d     = req_wdata;
                    wait_cnt_d  = WAIT_CNT_W'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_ready_d = 1'b0;
                if (wait_cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = access_err_c;
                    rsp_rdata_d = (write_q || access_err_c) ? '0 : load_data_c;
                    mem_we_c    = write_q && !access_err_c;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses WAIT_CYCLES=1,
// instance 1 uses WAIT_CYCLES=3 for the reset-abort scenario.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_ready;
    wire  [1:0]       req_ready;
    wire  [1:0]       rsp_valid;
    wire  [1:0][31:0] rsp_rdata;
    wire  [1:0]       rsp_err;

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.WAIT_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance d; lat = edges from acceptance to rsp_valid.
    task automatic xact(input int d, input logic w, input logic [31:0] a,
                        input logic [2:0] f, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("req_ready_timeout", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = w;
        req_addr[d]   = a;
        req_funct3[d] = f;
        req_wdata[d]  = wd;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) check("rsp_valid_timeout", 32'(rsp_valid[d]), 32'd1);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst = 2'b00; req_valid = '0; req_write = '0; req_addr = '0;
        req_funct3 = '0; req_wdata = '0; rsp_ready = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
        @(negedge clk);
        rst = 2'b11;
        #1;
        check("rel_req_ready_pre", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("rel_req_ready_post", 32'(req_ready[0]), 32'd1);
        check("rel_rsp_valid", 32'(rsp_valid[0]), 32'd0);

        // SW/LW round trip with latency
        xact(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", 32'(er), 32'd0);
        check("sw_lat", 32'(lat), 32'd2);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", 32'(er), 32'd0);
        check("lw_lat", 32'(lat), 32'd2);

        // Byte lanes
        xact(0, 1'b1, 32'h20, 3'b010, 32'h11223344, rd, er, lat);
        xact(0, 1'b1, 32'h23, 3'b000, 32'h00000080, rd, er, lat);
        check("sb_err", 32'(er), 32'd0);
        xact(0, 1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        check("lanes_lw", rd, 32'h80223344);
        xact(0, 1'b0, 32'h23, 3'b000, 32'h0, rd, er, lat);
        check("lanes_lb", rd, 32'hFFFFFF80);
        xact(0, 1'b0, 32'h23, 3'b100, 32'h0, rd, er, lat);
        check("lanes_lbu", rd, 32'h00000080);
        xact(0, 1'b0, 32'h22, 3'b001, 32'h0, rd, er, lat);
        check("lanes_lh", rd, 32'hFFFF8022);
        xact(0, 1'b0, 32'h22, 3'b101, 32'h0, rd, er, lat);
        check("lanes_lhu", rd, 32'h00008022);
        xact(0, 1'b1, 32'h20, 3'b001, 32'h0000BEEF, rd, er, lat);
        xact(0, 1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        check("sh_low_merge", rd, 32'h8022BEEF);

        // Errors
        xact(0, 1'b0, 32'h21, 3'b010, 32'h0, rd, er, lat);
        check("lw_mis_err", 32'(er), 32'd1);
        check("lw_mis_rdata", rd, 32'd0);
        xact(0, 1'b1, 32'h24, 3'b010, 32'h55667788, rd, er, lat);
        xact(0, 1'b1, 32'h25, 3'b001, 32'h0000AAAA, rd, er, lat);
        check("sh_mis_err", 32'(er), 32'd1);
        xact(0, 1'b0, 32'h24, 3'b010, 32'h0, rd, er, lat);
        check("sh_mis_nowrite", rd, 32'h55667788);
        xact(0, 1'b0, 32'h1000, 3'b010, 32'h0, rd, er, lat);
        check("range_err", 32'(er), 32'd1);
        check("range_rdata", rd, 32'd0);
        xact(0, 1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat);
        check("f3_011_err", 32'(er), 32'd1);
        check("f3_011_rdata", rd, 32'd0);
        xact(0, 1'b1, 32'h10, 3'b011, 32'h12345678, rd, er, lat);
        check("sf3_011_err", 32'(er), 32'd1);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        check("sf3_011_nowrite", rd, 32'hDEADBEEF);

        // Back-pressure
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
        req_funct3[0] = 3'b010;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 0;
        while (rsp_valid[0] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        check("bp_rel_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_rel_req_ready", 32'(req_ready[0]), 32'd1);

        // Abort a store in WAIT on the WAIT_CYCLES=3 instance
        xact(1, 1'b1, 32'h30, 3'b010, 32'h01020304, rd, er, lat);
        check("b_sw_lat", 32'(lat), 32'd4);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h30;
        req_funct3[1] = 3'b010; req_wdata[1] = 32'hCAFEBABE;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("abort_pre_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        rst[1] = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready[1]), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("abort_rsp_rdata", rsp_rdata[1], 32'd0);
        check("abort_rsp_err",   32'(rsp_err[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b1;
        xact(1, 1'b0, 32'h30, 3'b010, 32'h0, rd, er, lat);
        check("abort_old_data", rd, 32'h01020304);
        check("abort_not_new", 32'(rd !== 32'hCAFEBABE), 32'd1);
        check("abort_lw_lat", 32'(lat), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
